// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline interlock and forwarding controller
package hazard_pkg;
    localparam int NUM_SLOTS = 3;

    typedef enum logic [1:0] {
        FWD_RF     = 2'd0,
        FWD_EXMEM  = 2'd1,
        FWD_MEMWB  = 2'd2,
        FWD_WBHOLD = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       load;
    } sb_slot_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares one ID operand against the EX/MEM/WB scoreboard slots
// slot 0 is EX; the nearest matching slot decides the forwarding distance
module hazard_match
    import hazard_pkg::*;
(
    input  logic                      use_op,
    input  logic                      valid,
    input  logic [4:0]                src,
    input  sb_slot_t [NUM_SLOTS-1:0]  slots,
    output logic                      hit,
    output logic                      is_load_hit,
    output fwd_sel_t                  distance
);
    logic [NUM_SLOTS-1:0] m;
    logic                 unused_ok;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++)
            m[i] = use_op & valid & slots[i].v & (slots[i].dst == src);
        hit         = |m;
        is_load_hit = m[0] & slots[0].load;
        distance    = m[0] ? FWD_EXMEM : m[1] ? FWD_MEMWB : m[2] ? FWD_WBHOLD : FWD_RF;
    end

    // load results are already in mem_wb once past EX
    assign unused_ok = ^{slots[1].load, slots[2].load};
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline interlock, bubble and forwarding-select controller
// define HAZARD_FWD_EN to enable operand forwarding; otherwise every scoreboard hit stalls
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter bit R0_IS_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_src_a,
    input  logic [4:0]  id_src_b,
    input  logic        id_use_a,
    input  logic        id_use_b,
    input  logic [4:0]  id_dst,
    input  logic        id_wr,
    input  logic        id_load,
    input  logic        flush,
    output logic        stall,
    output logic        bubble,
    output logic [1:0]  fwd_sel_a,
    output logic [1:0]  fwd_sel_b,
    output logic [15:0] stall_cnt
);
    sb_slot_t [NUM_SLOTS-1:0] sb_q, sb_d;
    logic [15:0]              stall_cnt_q, stall_cnt_d;
    logic                     hit_a, hit_b, ld_a, ld_b, enter;
    fwd_sel_t                 dist_a, dist_b;
    logic                     unused_ok;

    hazard_match u_match_a (
        .use_op(id_use_a), .valid(id_valid), .src(id_src_a), .slots(sb_q),
        .hit(hit_a), .is_load_hit(ld_a), .distance(dist_a)
    );

    hazard_match u_match_b (
        .use_op(id_use_b), .valid(id_valid), .src(id_src_b), .slots(sb_q),
        .hit(hit_b), .is_load_hit(ld_b), .distance(dist_b)
    );

    always_comb begin
`ifdef HAZARD_FWD_EN
        stall = ~flush & (ld_a | ld_b);
`else
        stall = ~flush & (hit_a | hit_b);
`endif
        bubble      = stall | flush;
        enter       = id_valid & id_wr & ~bubble & (!R0_IS_ZERO || id_dst != 5'd0);
        sb_d[2]     = sb_q[1];
        sb_d[1]     = sb_q[0];
        sb_d[0].v    = enter;
        sb_d[0].dst  = id_dst;
        sb_d[0].load = id_load;
        stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifdef HAZARD_FWD_EN
    fwd_sel_t fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    // a bubbled id_ex slot never consumes forwarded data
    always_comb begin
        fwd_a_d = bubble ? FWD_RF : dist_a;
        fwd_b_d = bubble ? FWD_RF : dist_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_sel_a = fwd_a_q;
    assign fwd_sel_b = fwd_b_q;
    assign unused_ok = ^{hit_a, hit_b};
`else
    assign fwd_sel_a = FWD_RF;
    assign fwd_sel_b = FWD_RF;
    assign unused_ok = ^{ld_a, ld_b, dist_a, dist_b};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven directed bench for hazard_ctrl, both HAZARD_FWD_EN builds
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_a, id_use_b, id_wr, id_load, flush;
    logic [4:0]  id_src_a, id_src_b, id_dst;
    logic        stall, bubble, stall0, bubble0;
    logic [1:0]  fwd_sel_a, fwd_sel_b, fwd0_a, fwd0_b;
    logic [15:0] stall_cnt, stall_cnt0;
    int          n_run = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.R0_IS_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_a(id_src_a),
        .id_src_b(id_src_b), .id_use_a(id_use_a), .id_use_b(id_use_b), .id_dst(id_dst),
        .id_wr(id_wr), .id_load(id_load), .flush(flush), .stall(stall), .bubble(bubble),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.R0_IS_ZERO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_a(id_src_a),
        .id_src_b(id_src_b), .id_use_a(id_use_a), .id_use_b(id_use_b), .id_dst(id_dst),
        .id_wr(id_wr), .id_load(id_load), .flush(flush), .stall(stall0), .bubble(bubble0),
        .fwd_sel_a(fwd0_a), .fwd_sel_b(fwd0_b), .stall_cnt(stall_cnt0)
    );

    typedef struct {
        logic        v;
        logic [4:0]  a, b;
        logic        ua, ub;
        logic [4:0]  d;
        logic        wr, ld, fl;
        logic        st, bu;
        logic [1:0]  fa, fb;
        logic [15:0] cnt;
        logic        c0, s0;
        logic [1:0]  f0;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [4:0] a, input logic [4:0] b,
                                input logic ua, input logic ub, input logic [4:0] d,
                                input logic wr, input logic ld, input logic fl, input logic st,
                                input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt,
                                input logic c0 = 1'b0, input logic s0 = 1'b0,
                                input logic [1:0] f0 = 2'd0);
        vec_t r;
        r.v = v; r.a = a; r.b = b; r.ua = ua; r.ub = ub; r.d = d;
        r.wr = wr; r.ld = ld; r.fl = fl; r.st = st; r.bu = st | fl;
        r.fa = fa; r.fb = fb; r.cnt = cnt; r.c0 = c0; r.s0 = s0; r.f0 = f0;
        return r;
    endfunction

    function automatic vec_t nop(input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt,
                                 input logic c0 = 1'b0, input logic [1:0] f0 = 2'd0);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb, cnt, c0, 1'b0, f0);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        id_valid = r.v; id_src_a = r.a; id_src_b = r.b; id_use_a = r.ua; id_use_b = r.ub;
        id_dst = r.d; id_wr = r.wr; id_load = r.ld; flush = r.fl;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_stall"}, 16'(stall), 16'd0);
        chk({tag, "_bubble"}, 16'(bubble), 16'd0);
        chk({tag, "_fwd_a"}, 16'(fwd_sel_a), 16'd0);
        chk({tag, "_fwd_b"}, 16'(fwd_sel_b), 16'd0);
        chk({tag, "_cnt"}, stall_cnt, 16'd0);
    endtask

    initial begin
`ifdef HAZARD_FWD_EN
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));   // ADD r3,r1,r2
        tbl.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0));   // ADD r4,r3,r1: forwarded
        tbl.push_back(nop(1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0));   // LW r5
        tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0));   // ADD r6,r5,r5: load-use
        tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(nop(2, 2, 1));
        tbl.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1));   // ADD r0,r1,r2
        tbl.push_back(mk(1, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0)); // ADD r7,r0,r0
        tbl.push_back(nop(0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 1));   // ADD r3
        tbl.push_back(nop(0, 0, 1));
        tbl.push_back(nop(0, 0, 1));
        tbl.push_back(mk(1, 1, 3, 1, 1, 8, 1, 0, 0, 0, 0, 0, 1));   // r3 from WB hold
        tbl.push_back(nop(0, 3, 1));
        tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 1));   // ADD r5
        tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 1, 0, 0, 0, 1));   // flushed consumer
        tbl.push_back(nop(0, 0, 1));
`else
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));   // ADD r3,r1,r2
        tbl.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 0, 0, 0));   // d=1: three stalls
        tbl.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 3));   // ADD r5
        tbl.push_back(mk(1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 0, 0, 3));   // independent
        tbl.push_back(mk(1, 5, 1, 1, 1, 10, 1, 0, 0, 1, 0, 0, 3));  // d=2: two stalls
        tbl.push_back(mk(1, 5, 1, 1, 1, 10, 1, 0, 0, 1, 0, 0, 4));
        tbl.push_back(mk(1, 5, 1, 1, 1, 10, 1, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0)); // ADD r0
        tbl.push_back(mk(1, 0, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 5, 1, 1, 0)); // ADD r7,r0,r0
        tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 5));   // ADD r3
        tbl.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 0, 0, 5));
        tbl.push_back(mk(1, 3, 1, 1, 1, 4, 1, 0, 1, 0, 0, 0, 6));   // flush mid-interlock
        tbl.push_back(nop(0, 0, 6));
`endif
        rst_n = 1'b0;
        drive(mk(1, 3, 3, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        #2 chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(nop(0, 0, 0));
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #2;
            chk($sformatf("row%0d_stall", i), 16'(stall), 16'(tbl[i].st));
            chk($sformatf("row%0d_bubble", i), 16'(bubble), 16'(tbl[i].bu));
            chk($sformatf("row%0d_fwd_a", i), 16'(fwd_sel_a), 16'(tbl[i].fa));
            chk($sformatf("row%0d_fwd_b", i), 16'(fwd_sel_b), 16'(tbl[i].fb));
            chk($sformatf("row%0d_cnt", i), stall_cnt, tbl[i].cnt);
            if (tbl[i].c0) begin
                chk($sformatf("row%0d_r0_stall", i), 16'(stall0), 16'(tbl[i].s0));
                chk($sformatf("row%0d_r0_fwd_a", i), 16'(fwd0_a), 16'(tbl[i].f0));
            end
        end
        // load-use interlock, then asynchronous reset between clock edges
        @(negedge clk);
        drive(mk(1, 1, 2, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        #2 chk("pre_rst_stall", 16'(stall), 16'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        @(negedge clk);
        drive(nop(0, 0, 0));
        rst_n = 1'b1;
        @(negedge clk);
        drive(mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        #2 chk("post_rst_issue", 16'(stall), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
